// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush request and halt-code bundle between the pipeline stages and pipe_stall_ctrl.
// The master side raises requests; the slave side (pipe_stall_ctrl) returns halt codes and status.
interface pipe_stall_ctrl_if;
    logic        if_stall_req;
    logic        id_stall_req;
    logic        ex_flush_req;
    logic        mem_stall_req;
    logic [1:0]  pc_halt;
    logic [1:0]  if_id_halt;
    logic [1:0]  id_ex_halt;
    logic [1:0]  ex_mem_halt;
    logic [1:0]  mem_wb_halt;
    logic        if_abort;
    logic        stall_timeout;
    logic [31:0] perf_mem_stall;
    logic [31:0] perf_flush;

    modport master (
        output if_stall_req, id_stall_req, ex_flush_req, mem_stall_req,
        input  pc_halt, if_id_halt, id_ex_halt, ex_mem_halt, mem_wb_halt,
        input  if_abort, stall_timeout, perf_mem_stall, perf_flush
    );

    modport slave (
        input  if_stall_req, id_stall_req, ex_flush_req, mem_stall_req,
        output pc_halt, if_id_halt, id_ex_halt, ex_mem_halt, mem_wb_halt,
        output if_abort, stall_timeout, perf_mem_stall, perf_flush
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline with a consecutive-stall watchdog.
// Optional performance counters are built when STALL_PERF_EN is defined.
module pipe_stall_ctrl #(
    parameter int WD_W     = 8,
    parameter int WD_LIMIT = 200
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.slave bus
);

    localparam logic [1:0] H_ADV  = 2'b00;
    localparam logic [1:0] H_RES  = 2'b01;
    localparam logic [1:0] H_BUB  = 2'b10;
    localparam logic [1:0] H_HOLD = 2'b11;

    localparam logic [WD_W-1:0] WD_MATCH = WD_W'(WD_LIMIT - 1);
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

    // The one-cycle release is decoded as MEM_WAIT with mem_stall_req low; state then returns to RUN.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              flush_pend_q, flush_pend_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              timeout_q, timeout_d;

    logic [1:0]        pc_s, if_id_s, id_ex_s, ex_mem_s, mem_wb_s;
    logic              mem_row_s;
    logic              lite_stall_s;
    logic              flush_apply_s;
    logic              stall_row_s;

    // State, pending-flush, watchdog and timeout registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    // Priority resolution, next state and halt-code generation
    always_comb begin
        state_d       = state_q;
        flush_pend_d  = flush_pend_q;
        pc_s          = H_ADV;
        if_id_s       = H_ADV;
        id_ex_s       = H_ADV;
        ex_mem_s      = H_ADV;
        mem_wb_s      = H_ADV;
        mem_row_s     = 1'b0;
        lite_stall_s  = 1'b0;
        flush_apply_s = 1'b0;

        if (rst) begin
            state_d      = RUN;
            flush_pend_d = 1'b0;
            pc_s         = H_BUB;
            if_id_s      = H_BUB;
            id_ex_s      = H_BUB;
            ex_mem_s     = H_BUB;
            mem_wb_s     = H_BUB;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.mem_stall_req) begin
                        {pc_s, if_id_s, id_ex_s, ex_mem_s, mem_wb_s} = {H_HOLD, H_HOLD, H_HOLD, H_HOLD, H_BUB};
                        mem_row_s    = 1'b1;
                        state_d      = MEM_WAIT;
                        flush_pend_d = bus.ex_flush_req;
                    end else if (bus.ex_flush_req) begin
                        {pc_s, if_id_s, id_ex_s, ex_mem_s, mem_wb_s} = {H_ADV, H_BUB, H_BUB, H_ADV, H_ADV};
                        flush_apply_s = 1'b1;
                    end else if (bus.id_stall_req) begin
                        {pc_s, if_id_s, id_ex_s, ex_mem_s, mem_wb_s} = {H_HOLD, H_HOLD, H_BUB, H_ADV, H_ADV};
                        lite_stall_s = 1'b1;
                    end else if (bus.if_stall_req) begin
                        {pc_s, if_id_s, id_ex_s, ex_mem_s, mem_wb_s} = {H_HOLD, H_BUB, H_ADV, H_ADV, H_ADV};
                        lite_stall_s = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_stall_req) begin
                        {pc_s, if_id_s, id_ex_s, ex_mem_s, mem_wb_s} = {H_HOLD, H_HOLD, H_HOLD, H_HOLD, H_BUB};
                        mem_row_s = 1'b1;
                        if (bus.ex_flush_req) begin
                            flush_pend_d = 1'b1;
                        end else begin
                            flush_pend_d = flush_pend_q;
                        end
                    end else begin
                        // Release cycle: held stages resume; id/if requests are deliberately ignored here.
                        state_d      = RUN;
                        flush_pend_d = 1'b0;
                        if (flush_pend_q || bus.ex_flush_req) begin
                            {pc_s, if_id_s, id_ex_s, ex_mem_s, mem_wb_s} = {H_RES, H_BUB, H_BUB, H_RES, H_ADV};
                            flush_apply_s = 1'b1;
                        end else begin
                            {pc_s, if_id_s, id_ex_s, ex_mem_s, mem_wb_s} = {H_RES, H_RES, H_RES, H_RES, H_ADV};
                        end
                    end
                end
                default: begin
                    state_d      = RUN;
                    flush_pend_d = 1'b0;
                end
            endcase
        end
    end

    assign stall_row_s = mem_row_s | lite_stall_s;

    // Watchdog: count consecutive stall rows, saturating; any non-stall cycle clears it
    always_comb begin
        wd_cnt_d  = '0;
        timeout_d = timeout_q;
        if (stall_row_s) begin
            wd_cnt_d  = (wd_cnt_q == '1) ? wd_cnt_q : (wd_cnt_q + WD_ONE);
            timeout_d = timeout_q | (wd_cnt_q == WD_MATCH);
        end else begin
            wd_cnt_d  = '0;
            timeout_d = timeout_q;
        end
    end

    assign bus.pc_halt       = pc_s;
    assign bus.if_id_halt    = if_id_s;
    assign bus.id_ex_halt    = id_ex_s;
    assign bus.ex_mem_halt   = ex_mem_s;
    assign bus.mem_wb_halt   = mem_wb_s;
    assign bus.if_abort      = flush_apply_s;
    assign bus.stall_timeout = timeout_q;

`ifdef STALL_PERF_EN
    logic [31:0] perf_mem_q;
    logic [31:0] perf_flush_q;

    // Performance counters: MEM-stall cycles and applied flushes, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mem_q   <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            perf_mem_q   <= perf_mem_q + {31'h0, mem_row_s};
            perf_flush_q <= perf_flush_q + {31'h0, flush_apply_s};
        end
    end

    assign bus.perf_mem_stall = perf_mem_q;
    assign bus.perf_flush     = perf_flush_q;
`else
    assign bus.perf_mem_stall = 32'h0;
    assign bus.perf_flush     = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl; halt codes are checked as one packed
// 10-bit vector {pc, if_id, id_ex, ex_mem, mem_wb}. WD_LIMIT is reduced to 4.
module tb_pipe_stall_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(.WD_W(8), .WD_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef STALL_PERF_EN
    localparam logic PERF_ON = 1'b1;
`else
    localparam logic PERF_ON = 1'b0;
`endif

    localparam logic [9:0] R_BUB   = 10'b10_10_10_10_10;
    localparam logic [9:0] R_ADV   = 10'b00_00_00_00_00;
    localparam logic [9:0] R_MEM   = 10'b11_11_11_11_10;
    localparam logic [9:0] R_FLUSH = 10'b00_10_10_00_00;
    localparam logic [9:0] R_ID    = 10'b11_11_10_00_00;
    localparam logic [9:0] R_IF    = 10'b11_10_00_00_00;
    localparam logic [9:0] R_RELF  = 10'b01_10_10_01_00;
    localparam logic [9:0] R_REL   = 10'b01_01_01_01_00;

    logic [9:0] halts;
    assign halts = {bus.pc_halt, bus.if_id_halt, bus.id_ex_halt, bus.ex_mem_halt, bus.mem_wb_halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic mem, input logic fl, input logic id, input logic ifs);
        bus.mem_stall_req = mem;
        bus.ex_flush_req  = fl;
        bus.id_stall_req  = id;
        bus.if_stall_req  = ifs;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (halts !== R_BUB || bus.if_abort !== 1'b0 || bus.stall_timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d halts=%b abort=%b to=%b exp halts=%b abort=0 to=0",
                         i, halts, bus.if_abort, bus.stall_timeout, R_BUB);
            end
            next_cycle();
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (halts !== R_ADV || bus.if_abort !== 1'b0 || bus.perf_flush !== 32'h0 || bus.perf_mem_stall !== 32'h0) begin
            errors++;
            $display("FAIL reset_release halts=%b abort=%b pf=%0d pm=%0d exp all zero",
                     halts, bus.if_abort, bus.perf_flush, bus.perf_mem_stall);
        end
        next_cycle();
    endtask

    task automatic test_id_stall;
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (halts !== R_ID) begin
            errors++;
            $display("FAIL id_row halts=%b exp=%b", halts, R_ID);
        end
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (halts !== R_ADV) begin
            errors++;
            $display("FAIL id_after halts=%b exp=%b", halts, R_ADV);
        end
        next_cycle();
    endtask

    task automatic test_mem_flush;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, (i == 1), 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (halts !== R_MEM || bus.if_abort !== 1'b0) begin
                errors++;
                $display("FAIL mem_row cyc%0d halts=%b abort=%b exp=%b abort=0", i, halts, bus.if_abort, R_MEM);
            end
            next_cycle();
        end
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (halts !== R_RELF || bus.if_abort !== 1'b1) begin
            errors++;
            $display("FAIL mem_release_flush halts=%b abort=%b exp=%b abort=1", halts, bus.if_abort, R_RELF);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (halts !== R_ADV || bus.if_abort !== 1'b0) begin
            errors++;
            $display("FAIL mem_after halts=%b abort=%b exp=%b abort=0", halts, bus.if_abort, R_ADV);
        end
        checks++;
        if (bus.perf_flush !== (PERF_ON ? 32'd1 : 32'd0) || bus.perf_mem_stall !== (PERF_ON ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL perf_after_mem pf=%0d pm=%0d exp pf=%0d pm=%0d", bus.perf_flush, bus.perf_mem_stall,
                     PERF_ON ? 1 : 0, PERF_ON ? 3 : 0);
        end
        next_cycle();
    endtask

    task automatic test_release_no_flush;
        set_req(1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_req(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (halts !== R_REL || bus.if_abort !== 1'b0) begin
            errors++;
            $display("FAIL release_plain halts=%b abort=%b exp=%b abort=0", halts, bus.if_abort, R_REL);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (halts !== R_ID) begin
            errors++;
            $display("FAIL release_id_reassert halts=%b exp=%b", halts, R_ID);
        end
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
    endtask

    task automatic test_priority;
        set_req(1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (halts !== R_MEM || bus.if_abort !== 1'b0) begin
            errors++;
            $display("FAIL prio_all halts=%b abort=%b exp=%b abort=0", halts, bus.if_abort, R_MEM);
        end
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (halts !== R_RELF || bus.if_abort !== 1'b1) begin
            errors++;
            $display("FAIL prio_release halts=%b abort=%b exp=%b abort=1", halts, bus.if_abort, R_RELF);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (halts !== R_ADV || bus.if_abort !== 1'b0) begin
            errors++;
            $display("FAIL prio_once halts=%b abort=%b exp=%b abort=0", halts, bus.if_abort, R_ADV);
        end
        next_cycle();
    endtask

    task automatic test_flush_run;
        set_req(1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (halts !== R_FLUSH || bus.if_abort !== 1'b1) begin
            errors++;
            $display("FAIL flush_run halts=%b abort=%b exp=%b abort=1", halts, bus.if_abort, R_FLUSH);
        end
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (halts !== R_IF || bus.if_abort !== 1'b0) begin
            errors++;
            $display("FAIL if_row halts=%b abort=%b exp=%b abort=0", halts, bus.if_abort, R_IF);
        end
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.perf_flush !== (PERF_ON ? 32'd3 : 32'd0) || bus.perf_mem_stall !== (PERF_ON ? 32'd5 : 32'd0)) begin
            errors++;
            $display("FAIL perf_totals pf=%0d pm=%0d exp pf=%0d pm=%0d", bus.perf_flush, bus.perf_mem_stall,
                     PERF_ON ? 3 : 0, PERF_ON ? 5 : 0);
        end
        next_cycle();
    endtask

    task automatic test_rst_mid_stall;
        set_req(1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (halts !== R_BUB || bus.if_abort !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid halts=%b abort=%b exp=%b abort=0", halts, bus.if_abort, R_BUB);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (halts !== R_ADV || bus.if_abort !== 1'b0 || bus.perf_flush !== 32'h0 || bus.perf_mem_stall !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_after halts=%b abort=%b pf=%0d pm=%0d exp halts=%b abort=0 perf=0",
                     halts, bus.if_abort, bus.perf_flush, bus.perf_mem_stall, R_ADV);
        end
        next_cycle();
    endtask

    task automatic test_watchdog;
        // Two 3-cycle streaks separated by a gap must not trip the watchdog
        for (int i = 0; i < 7; i++) begin
            set_req(1'b0, 1'b0, 1'b0, (i != 3));
            next_cycle();
        end
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.stall_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wd_gap_clear to=%b exp=0", bus.stall_timeout);
        end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            set_req(1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            checks++;
            if (bus.stall_timeout !== 1'b0 || halts !== R_IF) begin
                errors++;
                $display("FAIL wd_streak cyc%0d to=%b halts=%b exp to=0 halts=%b", i, bus.stall_timeout, halts, R_IF);
            end
            next_cycle();
        end
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.stall_timeout !== 1'b1) begin
                errors++;
                $display("FAIL wd_sticky cyc%0d to=%b exp=1", i, bus.stall_timeout);
            end
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stall_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wd_rst_clear to=%b exp=0", bus.stall_timeout);
        end
        next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        test_reset();
        test_id_stall();
        test_mem_flush();
        test_release_no_flush();
        test_priority();
        test_flush_run();
        test_rst_mid_stall();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
